// File: rtl/pc_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM controller for the 9-bit miniMips core: owns the PC,
// steps decoder/ALU/data memory and halts on HALT_INSTR. Optional cycle_cnt via SEQ_CYCLE_COUNT_EN.
module pc_sequencer #(
    parameter int unsigned       PC_W       = 10,
    parameter logic [8:0]        HALT_INSTR = 9'h1FF,
    parameter logic [PC_W-1:0]   START_PC   = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [PC_W-1:0] imem_addr,
    input  logic [8:0]      imem_data,
    output logic [8:0]      instr,
    input  logic            is_mem_op,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic            exec_en,
    output logic            mem_req,
    input  logic            mem_ack,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            done,
    output logic [15:0]     retired_cnt
`ifdef SEQ_CYCLE_COUNT_EN
    ,
    output logic [23:0]     cycle_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_start_q;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;
    logic [PC_W-1:0] w_pc_inc;
    logic [8:0]      r_instr;
    logic [15:0]     r_retired;
    logic            w_edge;
    logic            w_run_start;
    logic            w_retire;
    logic            w_load_instr;

    assign w_edge    = start & ~r_start_q;
    assign w_pc_inc  = r_pc + PC_W'(1);
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign instr     = r_instr;
    assign retired_cnt = r_retired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_start_q <= 1'b0;
            r_pc      <= START_PC;
            r_instr   <= '0;
            r_retired <= '0;
        end else begin
            r_state   <= w_state_next;
            r_start_q <= start;
            r_pc      <= w_pc_next;
            if (w_load_instr) begin
                r_instr <= imem_data;
            end
            if (w_run_start) begin
                r_retired <= '0;
            end else if (w_retire && (r_retired != 16'hFFFF)) begin
                r_retired <= r_retired + 16'd1;
            end
        end
    end

    // Outputs are pure decodes of the state, so an async reset drops mem_req at once.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_run_start  = 1'b0;
        w_retire     = 1'b0;
        w_load_instr = 1'b0;
        exec_en      = 1'b0;
        mem_req      = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                done = (r_state == S_DONE);
                if (w_edge) begin
                    w_state_next = S_FETCH;
                    w_pc_next    = START_PC;
                    w_run_start  = 1'b1;
                end
            end
            S_FETCH: begin
                busy         = 1'b1;
                w_load_instr = 1'b1;
                w_state_next = S_EXEC;
            end
            S_EXEC: begin
                busy    = 1'b1;
                exec_en = 1'b1;
                if (r_instr == HALT_INSTR) begin
                    w_state_next = S_DONE;
                end else if (is_mem_op) begin
                    // memory path has priority over a coincident branch
                    w_state_next = S_MEM;
                end else begin
                    w_pc_next    = branch_taken ? branch_target : w_pc_inc;
                    w_retire     = 1'b1;
                    w_state_next = S_FETCH;
                end
            end
            S_MEM: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                if (mem_ack) begin
                    w_pc_next    = w_pc_inc;
                    w_retire     = 1'b1;
                    w_state_next = S_FETCH;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

`ifdef SEQ_CYCLE_COUNT_EN
    logic [23:0] r_cycle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle <= '0;
        end else if (w_run_start) begin
            r_cycle <= '0;
        end else if (busy && (r_cycle != 24'hFFFFFF)) begin
            r_cycle <= r_cycle + 24'd1;
        end
    end

    assign cycle_cnt = r_cycle;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: an ISA-level walk of each program predicts the
// executed (pc, instr) trace and final state; a monitor checks them as exec_en/done appear.
`timescale 1ns/1ps
module tb_pc_sequencer;

    localparam logic [8:0] HALT = 9'h1FF;
    localparam logic [8:0] MEMI = 9'h140;
    localparam logic [9:0] SPC  = 10'h000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  imem_addr;
    logic [8:0]  imem_data;
    logic [8:0]  instr;
    logic        is_mem_op;
    logic        branch_taken;
    logic [9:0]  branch_target;
    logic        exec_en;
    logic        mem_req;
    logic        mem_ack;
    logic [9:0]  pc;
    logic        busy;
    logic        done;
    logic [15:0] retired_cnt;
`ifdef SEQ_CYCLE_COUNT_EN
    logic [23:0] cycle_cnt;
`endif

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_addr(imem_addr), .imem_data(imem_data), .instr(instr),
        .is_mem_op(is_mem_op), .branch_taken(branch_taken), .branch_target(branch_target),
        .exec_en(exec_en), .mem_req(mem_req), .mem_ack(mem_ack),
        .pc(pc), .busy(busy), .done(done), .retired_cnt(retired_cnt)
`ifdef SEQ_CYCLE_COUNT_EN
        , .cycle_cnt(cycle_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [9:0] pc; logic [8:0] ins; bit mem; } exp_t;
    typedef struct { logic [15:0] ret; logic [9:0] pc; } fin_t;
    exp_t exp_q[$];
    fin_t fin_q[$];
    int   ack_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b1;
    int force_d = -1;

    logic [8:0] imem [0:1023];
    logic       br_tk [0:255];
    logic [9:0] br_tg [0:255];
    int exec_seen = 0;
    int run_base = 0;
    int step_idx;

    always @(posedge clk) if (exec_en) exec_seen <= exec_seen + 1;

    // Environment: combinational imem, decoder and per-step ALU branch outcome
    always_comb begin
        step_idx  = exec_seen - run_base;
        imem_data = imem[imem_addr];
        is_mem_op = (instr[8:6] == 3'b101);
        branch_taken  = 1'b0;
        branch_target = '0;
        if (step_idx >= 0 && step_idx < 256) begin
            branch_taken  = br_tk[step_idx[7:0]];
            branch_target = br_tg[step_idx[7:0]];
        end
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Data-memory responder: acks after d extra cycles of mem_req
    initial begin
        int d;
        mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req) begin
                d = (force_d >= 0) ? force_d : int'($urandom_range(0, 4));
                ack_q.push_back(d);
                repeat (d) @(negedge clk);
                mem_ack = 1'b1;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        exp_t e;
        fin_t f;
        int d;
        int gap = 0;
        int req = 0;
        bit have_prev = 1'b0;
        bit prev_mem = 1'b0;
        bit done_prev = 1'b0;
        forever begin
            @(negedge clk);
            gap++;
            if (mem_req) req++;
            if (!mon_en) begin
                have_prev = 1'b0;
            end else begin
                if (exec_en) begin
                    if (exp_q.size() == 0) begin
                        chk("exec_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("exec_pc", 32'(pc), 32'(e.pc));
                        chk("exec_instr", 32'(instr), 32'(e.ins));
                        if (have_prev) begin
                            if (prev_mem) begin
                                d = (ack_q.size() > 0) ? ack_q.pop_front() : -99;
                                chk("mem_latency", gap, 3 + d);
                                chk("mem_req_cycles", req, d + 1);
                            end else begin
                                chk("alu_latency", gap, 2);
                            end
                        end
                        have_prev = 1'b1;
                        prev_mem  = e.mem;
                    end
                    gap = 0;
                    req = 0;
                end
                if (done && !done_prev) begin
                    if (fin_q.size() == 0) begin
                        chk("done_unexpected", 32'd1, 32'd0);
                    end else begin
                        f = fin_q.pop_front();
                        chk("retired_cnt", 32'(retired_cnt), 32'(f.ret));
                        chk("final_pc", 32'(pc), 32'(f.pc));
                        chk("busy_in_done", 32'(busy), 32'd0);
                    end
                    have_prev = 1'b0;
                end
            end
            done_prev = done;
        end
    end

    task automatic clear_prog();
        for (int i = 0; i < 1024; i++) imem[i] = HALT;
        for (int i = 0; i < 256; i++) begin
            br_tk[i] = 1'b0;
            br_tg[i] = '0;
        end
    endtask

    // ISA-level walk; with gen=1 it also picks forward branch outcomes as it goes
    task automatic model_run(input bit gen);
        logic [9:0] p;
        int ret;
        logic [8:0] w;
        bit m;
        p = SPC;
        ret = 0;
        for (int k = 0; k < 256; k++) begin
            w = imem[p];
            m = (w != HALT) && (w[8:6] == 3'b101);
            if (gen) begin
                br_tk[k] = ($urandom_range(0, 2) == 0);
                br_tg[k] = p + 10'($urandom_range(2, 8));
            end
            exp_q.push_back('{p, w, m});
            if (w == HALT) break;
            ret++;
            if (m) p = p + 10'd1;
            else if (br_tk[k]) p = br_tg[k];
            else p = p + 10'd1;
        end
        fin_q.push_back('{(ret > 65535) ? 16'hFFFF : 16'(ret), p});
    endtask

    task automatic run_prog(input bit gen, input int mid_start, input int exp_busy);
        int busy_cyc;
        int t;
        busy_cyc = 0;
        t = 0;
        model_run(gen);
        @(negedge clk);
        run_base = exec_seen;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done && t < 3000) begin
            if (busy) busy_cyc++;
            if (t == mid_start) start = 1'b1;
            if (t == mid_start + 1) start = 1'b0;
            @(negedge clk);
            t++;
        end
        start = 1'b0;
        if (t >= 3000) chk("done_timeout", 32'd0, 32'd1);
        if (exp_busy >= 0) begin
            chk("busy_cycles", busy_cyc, exp_busy);
`ifdef SEQ_CYCLE_COUNT_EN
            chk("cycle_cnt", 32'(cycle_cnt), exp_busy);
`endif
        end
        @(negedge clk);
        chk("trace_drained", exp_q.size(), 0);
        chk("done_held", 32'(done), 32'd1);
`ifdef SEQ_CYCLE_COUNT_EN
        if (exp_busy >= 0) chk("cycle_cnt_held", 32'(cycle_cnt), exp_busy);
`endif
        exp_q.delete();
        fin_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        clear_prog();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_pc", 32'(pc), 32'(SPC));
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_exec_en", 32'(exec_en), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_retired", 32'(retired_cnt), 32'd0);

        // three ALU ops then halt, with a start pulse while busy
        clear_prog();
        imem[0] = 9'h001; imem[1] = 9'h002; imem[2] = 9'h003;
        run_prog(1'b0, 3, 8);

        // branch taken at pc 5 to 0x040, then not taken
        clear_prog();
        for (int i = 0; i < 6; i++) imem[i] = 9'h011;
        br_tk[5] = 1'b1; br_tg[5] = 10'h040;
        run_prog(1'b0, -1, 14);
        br_tk[5] = 1'b0;
        run_prog(1'b0, -1, 14);

        // memory op with ack after 4 request cycles; coincident branch ignored
        clear_prog();
        imem[0] = MEMI;
        br_tk[0] = 1'b1; br_tg[0] = 10'h200;
        force_d = 3;
        run_prog(1'b0, 2, 8);
        force_d = -1;

        // pc wraps from 0x3FF to 0
        clear_prog();
        imem[0] = 9'h022; imem[10'h3FE] = 9'h023; imem[10'h3FF] = 9'h024;
        br_tk[0] = 1'b1; br_tg[0] = 10'h3FE;
        run_prog(1'b0, 5, 10);

        // two ALU ops + halt
        clear_prog();
        imem[0] = 9'h005; imem[1] = 9'h006;
        run_prog(1'b0, -1, 6);

        // randomized programs with forward branches and memory ops
        for (int r = 0; r < 12; r++) begin
            clear_prog();
            for (int i = 0; i < 48; i++) begin
                if ($urandom_range(0, 9) < 3) imem[i] = {3'b101, 6'($urandom_range(0, 63))};
                else imem[i] = 9'($urandom_range(0, 510));
            end
            run_prog(1'b1, int'($urandom_range(0, 6)), -1);
        end

        // async reset while a memory request is pending
        mon_en = 1'b0;
        clear_prog();
        imem[0] = 9'h001; imem[1] = 9'h002; imem[2] = MEMI;
        force_d = 20;
        @(negedge clk);
        run_base = exec_seen;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!mem_req && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("mem_req_before_reset", 32'(mem_req), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mid_pc", 32'(pc), 32'(SPC));
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        repeat (25) @(negedge clk);
        chk("rst_hold_mem_req", 32'(mem_req), 32'd0);
        ack_q.delete();
        force_d = -1;
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // recovery run after reset
        clear_prog();
        imem[0] = 9'h001; imem[1] = 9'h002; imem[2] = 9'h003;
        run_prog(1'b0, -1, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
